hdmi_src_switch_ctrl: RTL

HDMI_SRC_SWITCH_CTRL -- requirements
Module: hdmi_src_switch_ctrl

---
 rtl/hdmi_src_switch_ctrl.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_src_switch_ctrl.sv
// -----------------------------------------------------------------------------
// hdmi_src_switch_ctrl
//
// Purpose:
//   Sequences a glitch-free switch between two video sources (vga / ft) that
//   feed a shared HDMI transmitter. A source change is deferred to the next
//   vsync edge. The HDMI PLL is then reset and relocked. Video stays blanked
//   and audio stays muted until the PLL has locked and the new source has
//   delivered a number of complete frames. Loss of lock at any point re-runs
//   the PLL reset sequence. A lock that never arrives parks the block in FAULT.
//   FAULT recovers on its own when lock appears or a new source is requested.
//
// Parameters:
//   RST_CYCLES    - PLL reset pulse length in clk cycles (>= 1)
//   LOCK_TIMEOUT  - max clk cycles waited for PLL lock or for a vsync edge
//   SETTLE_FRAMES - vsync rising edges needed after lock before unblank (>= 1)
//
// Ports:
//   clk        in   single clock, all logic on its rising edge
//   reset_n    in   asynchronous active-low reset
//   sel_req    in   requested source (0 = vga, 1 = ft), asynchronous
//   vs_in      in   vsync of the currently selected source, asynchronous
//   pll_locked in   HDMI PLL lock indication, asynchronous
//   sel_out    out  source select driving the video mux and the PLL
//   pll_rst    out  PLL reset, active-high
//   blank      out  forces video DE low and RGB to zero downstream
//   mute       out  forces audio samples to zero downstream
//   busy       out  high whenever a switch/relock sequence is in progress
//   fault      out  high while waiting for a lock that timed out
// -----------------------------------------------------------------------------
module hdmi_src_switch_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sel_req,
    input  logic vs_in,
    input  logic pll_locked,
    output logic sel_out,
    output logic pll_rst,
    output logic blank,
    output logic mute,
    output logic busy,
    output logic fault
);

    // The one counter has to reach the larger of the two cycle limits.
    // SETTLE counts frames into the same register, so SETTLE_FRAMES is
    // expected to stay well below that range.
    localparam int MAX_COUNT = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_VS   = 3'd1,
        PLL_RST   = 3'd2,
        WAIT_LOCK = 3'd3,
        SETTLE    = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              sel_nxt;

    logic              sel_meta;
    logic              sel_s;
    logic              vs_meta;
    logic              vs_s;
    logic              vs_d;
    logic              lock_meta;
    logic              lock_s;

    logic              vs_edge;
    logic              sel_diff;

    logic              pll_rst_nxt;
    logic              blank_nxt;
    logic              mute_nxt;
    logic              busy_nxt;
    logic              fault_nxt;

    // Two-flop synchronizers for the three asynchronous inputs, plus one more
    // flop on the synchronized vsync so that its rising edge can be seen.
    // Everything clears in reset, so no stale edge or stale request can
    // appear right after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_meta  <= 1'b0;
            sel_s     <= 1'b0;
            vs_meta   <= 1'b0;
            vs_s      <= 1'b0;
            vs_d      <= 1'b0;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            sel_meta  <= sel_req;
            sel_s     <= sel_meta;
            vs_meta   <= vs_in;
            vs_s      <= vs_meta;
            vs_d      <= vs_s;
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // The edge is a single-cycle pulse: high in the first cycle in which
    // the synchronized vsync is seen high.
    assign vs_edge  = vs_s & ~vs_d;
    assign sel_diff = (sel_s != sel_out);

    // Next-state and source-select decision. A new source request always
    // beats a pending lock, timeout or settle completion, because finishing a
    // sequence for a source nobody wants any more only delays the real switch.
    // In IDLE, lock loss beats a request: relocking comes first, and the
    // request is still pending when IDLE is reached again.
    // In WAIT_VS, a request that is withdrawn before it takes effect simply
    // returns to IDLE.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_out;
        case (state)
            IDLE: begin
                if (!lock_s) begin
                    state_nxt = PLL_RST;
                end else if (sel_diff) begin
                    state_nxt = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (!sel_diff) begin
                    state_nxt = IDLE;
                end else if (vs_edge || (cnt == LOCK_LAST)) begin
                    state_nxt = PLL_RST;
                    sel_nxt   = sel_s;
                end
            end
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (sel_diff) begin
                    state_nxt = PLL_RST;
                    sel_nxt   = sel_s;
                end else if (lock_s) begin
                    state_nxt = SETTLE;
                end else if (cnt == LOCK_LAST) begin
                    state_nxt = FAULT;
                end
            end
            SETTLE: begin
                if (!lock_s || sel_diff) begin
                    state_nxt = PLL_RST;
                    sel_nxt   = sel_s;
                end else if (vs_edge && (cnt == SETTLE_LAST)) begin
                    state_nxt = IDLE;
                end
            end
            FAULT: begin
                if (sel_diff) begin
                    state_nxt = PLL_RST;
                    sel_nxt   = sel_s;
                end else if (lock_s) begin
                    state_nxt = SETTLE;
                end
            end
            default: begin
                state_nxt = PLL_RST;
            end
        endcase
    end

    // One shared counter. It clears whenever the state changes. In SETTLE it
    // counts vsync edges; in every other state it counts clk cycles. It holds
    // at all-ones instead of wrapping, so a long stay in IDLE or FAULT can
    // never produce a false terminal count.
    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_MAX) begin
            if (state == SETTLE) begin
                if (vs_edge) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end
    end

    // Output decode from the next state. The outputs are registered, so
    // each one changes on the same clk edge as the state it belongs to.
    always_comb begin
        pll_rst_nxt = 1'b0;
        blank_nxt   = 1'b1;
        mute_nxt    = 1'b1;
        busy_nxt    = 1'b1;
        fault_nxt   = 1'b0;
        case (state_nxt)
            IDLE: begin
                blank_nxt = 1'b0;
                mute_nxt  = 1'b0;
                busy_nxt  = 1'b0;
            end
            WAIT_VS: begin
                blank_nxt = 1'b0;
            end
            PLL_RST: begin
                pll_rst_nxt = 1'b1;
            end
            FAULT: begin
                fault_nxt = 1'b1;
            end
            default: begin
                pll_rst_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs. Reset puts the block straight
    // into PLL_RST with source 0. The power-up sequence therefore runs
    // without any request, and a mid-sequence reset aborts to the same point.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= PLL_RST;
            cnt     <= '0;
            sel_out <= 1'b0;
            pll_rst <= 1'b1;
            blank   <= 1'b1;
            mute    <= 1'b1;
            busy    <= 1'b1;
            fault   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sel_out <= sel_nxt;
            pll_rst <= pll_rst_nxt;
            blank   <= blank_nxt;
            mute    <= mute_nxt;
            busy    <= busy_nxt;
            fault   <= fault_nxt;
        end
    end

endmodule
